// File: rtl/l1mtx_ahb_mem_slave_if.sv
// AHB-Lite signal bundle between a bus-matrix output stage (master side)
// and the l1mtx_ahb_mem_slave responder (slave side).
interface l1mtx_ahb_mem_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic [31:0] HRUSER;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA, HRUSER
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA, HRUSER
    );
endinterface

// File: rtl/l1mtx_ahb_mem_slave.sv
// AHB-Lite memory responder for a bus-matrix MI port: fixed wait states, two-cycle ERROR,
// byte-lane writes. Optional write-protected low region under L1MTX_MEM_SLV_RO_REGION_EN.
module l1mtx_ahb_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned RO_WORDS    = 64
) (
    input logic                   HCLK,
    input logic                   HRESETn,
    l1mtx_ahb_mem_slave_if.slave  ahb
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]              off_q, off_d;
    logic                    wr_q, wr_d;
    logic [2:0]              size_q, size_d;
    logic                    rdy_q, err_q;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             mem [DEPTH];

    logic                    accept, req_err, ro_hit, wr_commit;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [3:0]              lanes;
    logic [31:0]             wmask, fwd_word;
    logic                    unused_bits;

    assign req_idx     = ahb.HADDR[ADDR_WIDTH+1:2];
    assign accept      = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign unused_bits = &{1'b0, ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

`ifdef L1MTX_MEM_SLV_RO_REGION_EN
    localparam int unsigned RO_CLAMP = (RO_WORDS > DEPTH) ? DEPTH : RO_WORDS;
    localparam logic [ADDR_WIDTH:0] RO_LIMIT = (ADDR_WIDTH+1)'(RO_CLAMP);
    assign ro_hit = ahb.HWRITE & ({1'b0, req_idx} < RO_LIMIT);
`else
    localparam int unsigned unused_ro_words = RO_WORDS;
    assign ro_hit = 1'b0;
`endif

    assign req_err = (ahb.HSIZE > 3'b010)
                   | ((ahb.HSIZE == 3'b001) & ahb.HADDR[0])
                   | ((ahb.HSIZE == 3'b010) & (|ahb.HADDR[1:0]))
                   | ro_hit;

    always_comb begin
        case (size_q)
            3'b000:  lanes = 4'b0001 << off_q;
            3'b001:  lanes = off_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{lanes[i]}};
        end
    end

    assign wr_commit = (state_q == ST_DATA) & wr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        wr_d    = wr_q;
        size_d  = size_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_DATA;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d  = req_idx;
                    off_d  = ahb.HADDR[1:0];
                    wr_d   = ahb.HWRITE;
                    size_d = ahb.HSIZE;
                    if (req_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    // Read data is registered, so a write committing on the same edge is merged in here.
    always_comb begin
        fwd_word = mem[idx_d];
        if (wr_commit && (idx_q == idx_d)) begin
            fwd_word = (fwd_word & ~wmask) | (ahb.HWDATA & wmask);
        end
        rdata_d = ((state_d == ST_DATA) && !wr_d) ? fwd_word : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            rdy_q   <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
            err_q   <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lanes[i]) mem[idx_q][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
            end
        end
    end

    assign ahb.HREADYOUT = rdy_q;
    assign ahb.HRESP     = {1'b0, err_q};
    assign ahb.HRDATA    = rdata_q;
    assign ahb.HRUSER    = '0;
endmodule

// File: tb/tb_l1mtx_ahb_mem_slave.sv
// Directed bench for l1mtx_ahb_mem_slave: one zero-wait and one 3-wait instance on a shared
// stimulus bus, with a scoreboard of expected data-phase results.
module tb_l1mtx_ahb_mem_slave;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        sel, hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;

    l1mtx_ahb_mem_slave_if if0 ();
    l1mtx_ahb_mem_slave_if if3 ();

    assign if0.HSEL   = hsel & ~sel;
    assign if3.HSEL   = hsel & sel;
    assign if0.HADDR  = haddr;   assign if3.HADDR  = haddr;
    assign if0.HTRANS = htrans;  assign if3.HTRANS = htrans;
    assign if0.HWRITE = hwrite;  assign if3.HWRITE = hwrite;
    assign if0.HSIZE  = hsize;   assign if3.HSIZE  = hsize;
    assign if0.HWDATA = hwdata;  assign if3.HWDATA = hwdata;
    assign if0.HREADY = if0.HREADYOUT;
    assign if3.HREADY = if3.HREADYOUT;

    l1mtx_ahb_mem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .RO_WORDS(64)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .ahb(if0.slave));
    l1mtx_ahb_mem_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .RO_WORDS(64)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .ahb(if3.slave));

    logic        m_ready;
    logic [1:0]  m_resp;
    logic [31:0] m_rdata;
    assign m_ready = sel ? if3.HREADYOUT : if0.HREADYOUT;
    assign m_resp  = sel ? if3.HRESP     : if0.HRESP;
    assign m_rdata = sel ? if3.HRDATA    : if0.HRDATA;

    // rd_mode: 0 = compare rdata, 1 = record only, 2 = expect the last recorded read
    typedef struct {
        string       tag;
        bit          err;
        int          rd_mode;
        logic [31:0] rdata;
        int          lows;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          dp_active = 0;
    int          lows = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dp_active = 0;
        end else begin
            if (dp_active) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL scoreboard_underflow observed=%0d expected=1", exp_q.size());
                end
                if (exp_q.size() > 0) begin
                    if (!m_ready) begin
                        lows++;
                        chk({exp_q[0].tag, "_resp_wait"}, 32'(m_resp), {31'd0, exp_q[0].err});
                        chk({exp_q[0].tag, "_rdata_wait"}, m_rdata, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk({e.tag, "_resp"}, 32'(m_resp), {31'd0, e.err});
                        chk({e.tag, "_lows"}, 32'(lows), 32'(e.lows));
                        if (e.rd_mode == 0) chk({e.tag, "_rdata"}, m_rdata, e.rdata);
                        else if (e.rd_mode == 2) chk({e.tag, "_rdata"}, m_rdata, last_rd);
                        last_rd = m_rdata;
                        dp_active = 0;
                    end
                end
            end
            if (hsel && m_ready && htrans[1]) begin
                dp_active = 1;
                lows = 0;
            end
        end
    end

    task automatic issue(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata, input bit err,
                         input logic [31:0] rdata, input int rd_mode = 0);
        exp_t e;
        e.tag     = tag;
        e.err     = err;
        e.rd_mode = (wr || err) ? 0 : rd_mode;
        e.rdata   = (wr || err) ? 32'd0 : rdata;
        e.lows    = err ? 1 : (sel ? 3 : 0);
        exp_q.push_back(e);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
        for (int n = 0; n <= 40; n++) begin
            @(negedge HCLK);
            if (m_ready) break;
            if (n == 40) begin
                checks++;
                failures++;
                $error("FAIL %s_accept observed=not_ready expected=ready", tag);
            end
        end
        @(posedge HCLK); #1;
        hwdata = wdata; htrans = 2'b00; hsel = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            @(posedge HCLK); #1;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL drain observed=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        sel = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'b010; hwdata = '0;
        #12;
        chk("rst0_ready", 32'(if0.HREADYOUT), 32'd1);
        chk("rst0_resp",  32'(if0.HRESP),     32'd0);
        chk("rst0_rdata", if0.HRDATA,         32'd0);
        chk("rst3_ready", 32'(if3.HREADYOUT), 32'd1);
        chk("rst3_rdata", if3.HRDATA,         32'd0);
        @(negedge HCLK); HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // zero-wait write then back-to-back read of the same word
        issue("w_beef", 1, 32'h1000_0200, 3'b010, 32'hDEAD_BEEF, 0, 0);
        issue("r_beef", 0, 32'h1000_0200, 3'b010, 0, 0, 32'hDEAD_BEEF);
        drain();

        // byte/halfword lanes into word 0x40
        issue("w_clr",  1, 32'h0000_0100, 3'b010, 32'h0000_0000, 0, 0);
        issue("w_b0",   1, 32'h0000_0100, 3'b000, 32'hFFFF_FF11, 0, 0);
        issue("w_b3",   1, 32'h0000_0103, 3'b000, 32'h22FF_FFFF, 0, 0);
        issue("w_h0",   1, 32'h0000_0100, 3'b001, 32'hFFFF_3344, 0, 0);
        issue("r_lane", 0, 32'h0000_0100, 3'b010, 0, 0, 32'h2200_3344);
        drain();

        // errors: misaligned word read with new NONSEQ in ERR2, odd halfword write, bad size
        issue("r_mis",  0, 32'h1000_0202, 3'b010, 0, 1, 0);
        issue("r_after_err", 0, 32'h1000_0200, 3'b010, 0, 0, 32'hDEAD_BEEF);
        issue("w_hodd", 1, 32'h0000_0101, 3'b001, 32'hAAAA_AAAA, 1, 0);
        issue("r_size", 0, 32'h0000_0100, 3'b011, 0, 1, 0);
        issue("r_nochg", 0, 32'h0000_0100, 3'b010, 0, 0, 32'h2200_3344);
        issue("r_alias", 0, 32'hFFFF_F100, 3'b010, 0, 0, 32'h2200_3344);
        drain();

`ifdef L1MTX_MEM_SLV_RO_REGION_EN
        issue("r_ro_pre",  0, 32'h0000_0028, 3'b010, 0, 0, 0, 1);
        issue("w_ro",      1, 32'h0000_0028, 3'b010, 32'h5A5A_5A5A, 1, 0);
        issue("r_ro_post", 0, 32'h0000_0028, 3'b010, 0, 0, 0, 2);
`else
        issue("w_ro",      1, 32'h0000_0028, 3'b010, 32'h5A5A_5A5A, 0, 0);
        issue("r_ro_post", 0, 32'h0000_0028, 3'b010, 0, 0, 32'h5A5A_5A5A);
`endif
        drain();
        chk("hruser0", if0.HRUSER, 32'd0);

        // three wait states on the second instance
        sel = 1'b1;
        issue("w3_cafe", 1, 32'h0000_0300, 3'b010, 32'hCAFE_F00D, 0, 0);
        issue("r3_cafe", 0, 32'h0000_0300, 3'b010, 0, 0, 32'hCAFE_F00D);
        issue("r3_mis",  0, 32'h0000_0301, 3'b010, 0, 1, 0);
        drain();
        chk("hruser3", if3.HRUSER, 32'd0);

        // reset during the wait states of a write
        issue("w3_drop", 1, 32'h0000_0300, 3'b010, 32'h1234_5678, 0, 0);
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(if3.HREADYOUT), 32'd1);
        chk("rst_mid_resp",  32'(if3.HRESP),     32'd0);
        chk("rst_mid_rdata", if3.HRDATA,         32'd0);
        exp_q.delete();
        #10 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        issue("r3_kept", 0, 32'h0000_0300, 3'b010, 0, 0, 32'hCAFE_F00D);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
